// File: rtl/bus_lane_arbiter_if.sv
// Handshake bundle between the requesters and the byte-lane bus arbiter.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface bus_lane_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_lanes;
  logic [NREQ-1:0]   gnt;
  logic              enh;
  logic              enl;
  logic              busy;
  logic [OW-1:0]     owner;

  modport master (output req, req_lanes, input gnt, enh, enl, busy, owner);
  modport slave  (input req, req_lanes, output gnt, enh, enl, busy, owner);
endinterface

// File: rtl/bus_lane_arbiter.sv
// Round-robin owner of the 16-bit byte-lane bus with a burst limit and lane enables.
// Optional dead cycle between owners: define BUS_LANE_ARB_TURNAROUND_EN.
//
// state  | meaning
// S_IDLE | no owner, outputs zero, arbitrating every cycle
// S_OWN  | gnt/enh/enl driven for r_owner, burst counter running
// S_TURN | one dead cycle after a release (turnaround build only)
module bus_lane_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input logic               clk,
  input logic               rst_n,
  bus_lane_arbiter_if.slave bus
);
  localparam int          OW    = $clog2(NREQ);
  localparam logic [7:0]  BURST = 8'(MAX_BURST);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

`ifdef BUS_LANE_ARB_TURNAROUND_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN = 2'd1, S_TURN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN = 2'd1} state_t;
`endif

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic            r_enh;
  logic            r_enl;
  logic            r_busy;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_ptr;
  logic [7:0]      r_cnt;

  logic [NREQ-1:0] w_elig;
  logic            w_found_hi;
  logic            w_found;
  logic [OW-1:0]   w_win_hi;
  logic [OW-1:0]   w_win_lo;
  logic [OW-1:0]   w_win;
  logic [1:0]      w_lanes_hi;
  logic [1:0]      w_lanes_lo;
  logic [1:0]      w_lanes;
  logic            w_owner_req;
  logic            w_contend;
  logic            w_release;
  logic            w_arb;
  logic            w_grant;

  // Indices above r_ptr win first, then wrap to 0..r_ptr, so the previous owner is considered last.
  always_comb begin
    w_elig     = '0;
    w_found_hi = 1'b0;
    w_found    = 1'b0;
    w_win_hi   = '0;
    w_win_lo   = '0;
    w_lanes_hi = 2'b00;
    w_lanes_lo = 2'b00;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_elig[i] = bus.req[i] & (|bus.req_lanes[2*i +: 2]);
      if (w_elig[i]) begin
        if (i > int'(r_ptr)) begin
          w_found_hi = 1'b1;
          w_win_hi   = OW'(i);
          w_lanes_hi = bus.req_lanes[2*i +: 2];
        end
        w_found    = 1'b1;
        w_win_lo   = OW'(i);
        w_lanes_lo = bus.req_lanes[2*i +: 2];
      end
    end
    w_win   = w_found_hi ? w_win_hi   : w_win_lo;
    w_lanes = w_found_hi ? w_lanes_hi : w_lanes_lo;
  end

  assign w_owner_req = |(bus.req & r_gnt);
  assign w_contend   = |(w_elig & ~r_gnt);
  assign w_release   = (r_state == S_OWN) &&
                       (!w_owner_req || ((r_cnt == BURST) && w_contend));

  always_comb begin
    w_arb = (r_state == S_IDLE);
`ifdef BUS_LANE_ARB_TURNAROUND_EN
    if (r_state == S_TURN) w_arb = 1'b1;
`else
    if (w_release) w_arb = 1'b1;
`endif
  end

  assign w_grant = w_arb && w_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_enh   <= 1'b0;
      r_enl   <= 1'b0;
      r_busy  <= 1'b0;
      r_owner <= '0;
      r_ptr   <= OW'(NREQ - 1);
      r_cnt   <= '0;
    end else if (w_grant) begin
      r_state <= S_OWN;
      r_gnt   <= ONE << w_win;
      r_enh   <= w_lanes[1];
      r_enl   <= w_lanes[0];
      r_busy  <= 1'b1;
      r_owner <= w_win;
      r_ptr   <= w_win;
      r_cnt   <= 8'd1;
    end else if (r_state == S_OWN && !w_release) begin
      // Uncontended owner at the limit keeps the bus; the count restarts.
      r_cnt <= (r_cnt == BURST) ? 8'd1 : r_cnt + 8'd1;
    end else begin
`ifdef BUS_LANE_ARB_TURNAROUND_EN
      r_state <= w_release ? S_TURN : S_IDLE;
`else
      r_state <= S_IDLE;
`endif
      r_gnt   <= '0;
      r_enh   <= 1'b0;
      r_enl   <= 1'b0;
      r_busy  <= 1'b0;
      r_owner <= '0;
      r_cnt   <= '0;
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.enh   = r_enh;
  assign bus.enl   = r_enl;
  assign bus.busy  = r_busy;
  assign bus.owner = r_owner;
endmodule

// File: tb/tb_bus_lane_arbiter.sv
// Directed scoreboard bench for bus_lane_arbiter (NREQ=4, MAX_BURST=8).
// Expected output words are queued as stimulus is applied and checked one cycle later.
module tb_bus_lane_arbiter;
  logic clk;
  logic rst_n;

  bus_lane_arbiter_if #(.NREQ(4)) bus ();

  bus_lane_arbiter #(.NREQ(4), .MAX_BURST(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef BUS_LANE_ARB_TURNAROUND_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [1:0] idx_of(logic [3:0] g);
    idx_of = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) idx_of = 2'(i);
  endfunction

  task automatic push(string tag, logic [3:0] g, logic h, logic l);
    sb_t e;
    e.tag = tag;
    e.exp = {g, h, l, |g, idx_of(g)};
    sb_q.push_back(e);
  endtask

  task automatic check_front();
    sb_t        e;
    logic [8:0] obs;
    if (sb_q.size() == 0) return;
    e   = sb_q.pop_front();
    obs = {bus.gnt, bus.enh, bus.enl, bus.busy, bus.owner};
    n_vec++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s observed gnt/enh/enl/busy/owner=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask

  task automatic exp_cycle(string tag, logic [3:0] g, logic h, logic l);
    push(tag, g, h, l);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push(tag, 4'b0000, 1'b0, 1'b0);
    check_front();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_lanes = '0;
    #12;
    push("reset_state", 4'b0000, 1'b0, 1'b0);
    check_front();
    @(negedge clk);
    rst_n = 1'b1;

    // requester 2 alone, high lane only
    bus.req       = 4'b0100;
    bus.req_lanes = 8'b00_10_00_00;
    exp_cycle("grant_latency_r2", 4'b0100, 1'b1, 1'b0);
    exp_cycle("hold_r2",          4'b0100, 1'b1, 1'b0);
    bus.req = 4'b0000;
    exp_cycle("release_r2",       4'b0000, 1'b0, 1'b0);
    exp_cycle("idle_after_r2",    4'b0000, 1'b0, 1'b0);

    // full contention: rotation with forced release at the burst limit
    do_reset("reset_before_rotate");
    bus.req       = 4'b1111;
    bus.req_lanes = 8'b11_11_11_11;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 8; c++) exp_cycle("rotate_tenure", 4'(1 << order[t]), 1'b1, 1'b1);
      if (t < 4) for (int g = 0; g < GAP; g++) exp_cycle("rotate_gap", 4'b0000, 1'b0, 1'b0);
    end
    bus.req = 4'b0000;
    exp_cycle("rotate_drop", 4'b0000, 1'b0, 1'b0);
    exp_cycle("rotate_idle", 4'b0000, 1'b0, 1'b0);

    // single requester past the burst limit keeps the bus
    bus.req       = 4'b0010;
    bus.req_lanes = 8'b00_00_11_00;
    for (int c = 0; c < 20; c++) exp_cycle("solo_r1_no_gap", 4'b0010, 1'b1, 1'b1);
    bus.req = 4'b0000;
    exp_cycle("solo_r1_release", 4'b0000, 1'b0, 1'b0);
    exp_cycle("solo_r1_idle",    4'b0000, 1'b0, 1'b0);

    // zero lane mask is not eligible
    bus.req       = 4'b1000;
    bus.req_lanes = 8'b00_00_00_00;
    for (int c = 0; c < 3; c++) exp_cycle("zero_lanes_ignored", 4'b0000, 1'b0, 1'b0);
    bus.req_lanes = 8'b01_00_00_00;
    exp_cycle("lanes_01_grant", 4'b1000, 1'b0, 1'b1);
    exp_cycle("lanes_01_hold",  4'b1000, 1'b0, 1'b1);
    bus.req = 4'b0000;
    exp_cycle("r3_release", 4'b0000, 1'b0, 1'b0);
    exp_cycle("r3_idle",    4'b0000, 1'b0, 1'b0);

    // lane mask captured at grant, later changes ignored
    bus.req       = 4'b0001;
    bus.req_lanes = 8'b00_00_00_11;
    exp_cycle("mask_grant", 4'b0001, 1'b1, 1'b1);
    exp_cycle("mask_hold",  4'b0001, 1'b1, 1'b1);
    bus.req_lanes = 8'b00_00_00_01;
    for (int c = 0; c < 3; c++) exp_cycle("mask_change_ignored", 4'b0001, 1'b1, 1'b1);
    bus.req = 4'b0000;
    exp_cycle("mask_release", 4'b0000, 1'b0, 1'b0);
    exp_cycle("mask_idle",    4'b0000, 1'b0, 1'b0);

    // asynchronous reset in the middle of requester 1's tenure
    bus.req       = 4'b0010;
    bus.req_lanes = 8'b00_00_11_00;
    exp_cycle("pre_reset_grant_r1", 4'b0010, 1'b1, 1'b1);
    exp_cycle("pre_reset_hold_r1",  4'b0010, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push("async_reset_drop", 4'b0000, 1'b0, 1'b0);
    check_front();
    bus.req       = 4'b1010;
    bus.req_lanes = 8'b11_00_11_00;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cycle("post_reset_first_r1", 4'b0010, 1'b1, 1'b1);
    exp_cycle("post_reset_hold_r1",  4'b0010, 1'b1, 1'b1);
    bus.req = 4'b1000;
    for (int g = 0; g < GAP; g++) exp_cycle("post_reset_gap", 4'b0000, 1'b0, 1'b0);
    exp_cycle("post_reset_next_r3", 4'b1000, 1'b1, 1'b1);
    bus.req = 4'b0000;
    exp_cycle("final_release", 4'b0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_lane_arbiter.md
# bus_lane_arbiter

Round-robin arbiter that shares the 16-bit byte-lane tri-state bus between `NREQ` requesters. It generates the one-hot grant and the `enh`/`enl` lane enables that drive the upper and lower `busdriver` byte slices. Ownership is bounded by a burst limit. An optional dead cycle separates owners so two drivers never overlap on the bus.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 8: maximum consecutive owned cycles while another requester waits (1..255).
- `clk` input 1: bus clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous active-low reset; synchronous deassertion provided externally.
- `req` input `NREQ`: request per requester; level, held until granted and done.
- `req_lanes` input `2*NREQ`: lane mask per requester; bit `2i+1` = high byte (`enh`), bit `2i` = low byte (`enl`).
- `gnt` output `NREQ`: registered one-hot grant; all zero when idle or turning.
- `enh` output 1: registered high-lane enable of current owner.
- `enl` output 1: registered low-lane enable of current owner.
- `busy` output 1: high while any grant is held.
- `owner` output `$clog2(NREQ)`: index of current owner; 0 when idle.

## Operation
- A request is eligible only when `req[i]=1` and its `req_lanes` pair is nonzero. A request with lanes `2'b00` is ignored.
- Round-robin arbitration: the search starts at `ptr+1` modulo `NREQ`, where `ptr` is the last granted index. The first eligible requester wins. `ptr` updates at each new grant.
- Lane mask is captured at the grant edge and held for the whole tenure. Changes to `req_lanes` during ownership are ignored.
- State IDLE: outputs zero. Any eligible request moves to OWN with the winner.
- State OWN: `gnt[owner]=1`, `enh`/`enl` from the captured mask. The burst counter increments each OWN cycle.
  - The owner deasserts `req`: release.
  - The counter reaches `MAX_BURST` while any other eligible request is pending: forced release.
  - The counter reaches `MAX_BURST` with no other request pending: counter restarts at 1 and ownership continues.
- Release goes to TURN (macro defined) or directly to arbitration (macro undefined). For the undefined case, see Configuration.
- State TURN: exactly one cycle with all outputs zero. Arbitration then runs with `ptr` = the released owner. The result is OWN(winner) or IDLE.
- A released owner still requesting is eligible again, but only after every other eligible requester has been considered.
- Reset at any time, including mid-tenure, asynchronously forces the following:
  - state IDLE;
  - `gnt=0`, `enh=0`, `enl=0`, `busy=0`, `owner=0`;
  - `ptr=NREQ-1`, so requester 0 wins first;
  - burst counter 0.

## Timing
- Grant latency from IDLE: `req` sampled high at edge N gives `gnt`/`enh`/`enl` high after edge N (one cycle).
- Release latency: `req` low sampled at edge N drops `gnt` after edge N.
- Handover with the macro defined: old grant low after edge N, TURN for one cycle, new grant after edge N+1. The bus has one dead cycle.
- Handover with the macro undefined: old grant low and new grant high after the same edge N.
- Forced release: with `MAX_BURST=8`, the owner holds `gnt` for exactly 8 cycles when contended.
- `gnt`, `enh`, `enl`, `busy`, `owner` change only on clock edges or on reset assertion. They never glitch combinationally.
- `enh|enl` implies `busy`. `gnt` is always one-hot or zero.

## Configuration
- `BUS_LANE_ARB_TURNAROUND_EN`
  - Defined: a TURN dead cycle follows every release, guaranteeing no two `busdriver` slices are enabled on adjacent cycles by different owners.
  - Undefined: there is no TURN state. Release and the next grant occur on the same edge. Use only when the drivers are guaranteed break-before-make.

## Test plan
- Reset, then `req=4'b0100`, `req_lanes` for requester 2 = `2'b10`: after one edge `gnt=4'b0100`, `enh=1`, `enl=0`, `owner=2`. Dropping `req` gives `gnt=0` one edge later.
- `req=4'b1111`, all lanes `2'b11`, held, `MAX_BURST=8`: grants rotate 0,1,2,3,0. Each tenure lasts 8 cycles, with one all-zero cycle between tenures when the macro is defined and none when it is undefined.
- Single requester 1 held for 20 cycles: `gnt=4'b0010` stays continuously high with no forced release or gap.
- Requester 3 with `req_lanes=2'b00` and `req=1` alone: it is never granted and `busy` stays 0. Changing its lanes to `2'b01` gives a grant with `enl=1` one edge later.
- Owner 0 with mask `2'b11` changes `req_lanes` to `2'b01` mid-tenure: `enh` and `enl` stay 1 until release.
- Assert `rst_n=0` mid-tenure, between clock edges: `gnt`, `enh`, `enl`, `busy` drop immediately. After release with `req=4'b1010`, requester 1 is granted first.
